double_sum_reducer: RTL and testbench
=====================================

Name: double_sum_reducer

Overview:
- Reduces a stream of IEEE-754 doubles, delimited into groups by a last flag, to one sum per group.
- Sits directly upstream of double_adder: drives its a/b operand handshakes, consumes its z result and keeps the running sum.
- Emits each group sum and its element count on a stb/ack output port. Used to sum Pair-HMM row probabilities.

Parameters:
- COUNT_W, 16, width of the element counter; the counter saturates at 2^COUNT_W-1.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- in_data  in  64  element, double bit pattern
- in_last  in  1  element is last of its group
- in_stb  in  1  element valid
- in_ack  out  1  ready to take element
- add_a  out  64  running sum to adder input_a
- add_a_stb  out  1  add_a valid
- add_a_ack  in  1  adder took add_a
- add_b  out  64  new element to adder input_b
- add_b_stb  out  1  add_b valid
- add_b_ack  in  1  adder took add_b
- add_z  in  64  adder output_z
- add_z_stb  in  1  add_z valid
- add_z_ack  out  1  result consumed
- out_sum  out  64  group sum
- out_count  out  COUNT_W  elements in group
- out_stb  out  1  out_sum/out_count valid
- out_ack  in  1  downstream took result

Behaviour:
- Transfer rule on every port: a word moves at a rising edge where stb and ack are both 1.
  - A producer holds stb and data stable until that edge.
  - The ack owner may hold ack high while idle.
- Reset (rst=0, any time, including mid-group):
  - Immediately clears all outputs, acc, count, hold regs and pending flags; state returns to GET_FIRST.
  - The partial group is discarded.
  - Reset values: in_ack=0, add_a_stb=0, add_b_stb=0, add_z_ack=0, out_stb=0, add_a/add_b/out_sum=0, out_count=0.
  - First cycle after reset release: in_ack=1.
- States:
  - GET_FIRST: in_ack=1.
    - On transfer: acc<=in_data, count<=1, last_q<=in_last.
    - If in_last, go to PUT_SUM; else go to GET_NEXT.
    - No add is issued, so the first element's bits, including -0.0 and NaN, pass unchanged.
  - GET_NEXT: in_ack=1.
    - On transfer: add_a<=acc, add_b<=in_data, add_a_stb<=1, add_b_stb<=1, last_q<=in_last.
    - count<=count+1, saturating at 2^COUNT_W-1. Go to SEND_AB.
  - SEND_AB: in_ack=0.
    - add_a_stb and add_b_stb clear independently, each at its own transfer edge.
    - Go to WAIT_Z in the cycle both have cleared. Simultaneous acks are legal.
  - WAIT_Z: add_z_ack=1.
    - On transfer: acc<=add_z, add_z_ack<=0.
    - Go to PUT_SUM if last_q, else GET_NEXT.
  - PUT_SUM: out_sum=acc, out_count=count, out_stb=1, in_ack=0.
    - On transfer: out_stb<=0 and go to GET_FIRST.
    - A back-to-back group is accepted from the next cycle onward.
- Latency:
  - Input transfer to add_*_stb high: 1 cycle.
  - add_z transfer to the next in_ack or to out_stb: 1 cycle.
  - Single-element group: out_stb high 1 cycle after the input transfer.
- No arithmetic is done here; all floating-point work is in double_adder. Exceptions and rounding are whatever the adder returns.
- Strobes are edge-exact: add_z_stb seen while the state is not WAIT_Z is ignored, because add_z_ack=0 there.

Decomposition:
- Shared package double_sum_pkg:
  - State enum: GET_FIRST, GET_NEXT, SEND_AB, WAIT_Z, PUT_SUM.
  - Localparam DBL_W=64.
  - Constants DBL_POS_ZERO=64'h0, DBL_ONE=64'h3FF0000000000000, for bench use.
- No sub-module: single FSM, about 200 lines. double_adder is instantiated beside it by the parent, not inside it.

Test Plan:
- Group 1.0, 2.0, 3.0 (last on 3.0), adder behind, out_ack=1 -> out_sum=64'h4018000000000000 (6.0), out_count=3, exactly one out_stb pulse.
- Single element 64'hBFF8000000000000 (-1.5) with last -> out_sum identical bits, out_count=1, add_a_stb never asserted, out_stb 1 cycle after transfer.
- out_ack held 0 for 20 cycles after out_stb -> out_sum/out_count stable, in_ack=0 throughout; release -> in_ack=1 on the next cycle.
- Bench-model adder raises add_a_ack 3 cycles before add_b_ack -> add_a_stb drops after its transfer, add_b_stb stays until its own; no duplicate operand transfer.
- rst pulled low for 1 cycle while in WAIT_Z -> all outputs 0 at once; next group {0.5, 0.25} -> 64'h3FE8000000000000 (0.75), count 2.
- Group 3.14, -3.14 -> out_sum=64'h0000000000000000 (+0.0); then 2^COUNT_W+5 elements of 0.0 -> out_count saturates at 2^COUNT_W-1.

Source files
------------

// File: rtl/double_sum_pkg.sv
// double_sum_pkg: shared state encoding and double constants for the sum reducer
package double_sum_pkg;
  localparam int DBL_W = 64;
  localparam logic [DBL_W-1:0] DBL_POS_ZERO = 64'h0;
  localparam logic [DBL_W-1:0] DBL_ONE = 64'h3FF0000000000000;
  typedef enum logic [2:0] {GET_FIRST, GET_NEXT, SEND_AB, WAIT_Z, PUT_SUM} state_t;
endpackage

// File: rtl/double_sum_reducer.sv
// double_sum_reducer: folds last-delimited groups of doubles into one sum per group via an external adder
// Ports: clk/rst (async active-low); in_* element stream; add_a/add_b operand
// handshakes and add_z result handshake to double_adder; out_sum/out_count result port.
module double_sum_reducer
  import double_sum_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DBL_W-1:0]   in_data,
  input  logic               in_last,
  input  logic               in_stb,
  output logic               in_ack,
  output logic [DBL_W-1:0]   add_a,
  output logic               add_a_stb,
  input  logic               add_a_ack,
  output logic [DBL_W-1:0]   add_b,
  output logic               add_b_stb,
  input  logic               add_b_ack,
  input  logic [DBL_W-1:0]   add_z,
  input  logic               add_z_stb,
  output logic               add_z_ack,
  output logic [DBL_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_stb,
  input  logic               out_ack
);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  state_t               state;
  logic [DBL_W-1:0]     acc;
  logic [COUNT_W-1:0]   count;
  logic                 last_q;
  logic                 in_xfer, z_xfer, a_done, b_done;
  assign in_xfer = in_stb && in_ack;
  assign z_xfer  = add_z_stb && add_z_ack;
  // an operand counts as delivered if its strobe is already down or is being taken this edge
  assign a_done  = !add_a_stb || add_a_ack;
  assign b_done  = !add_b_stb || add_b_ack;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= GET_FIRST;
      acc       <= '0;
      count     <= '0;
      last_q    <= 1'b0;
      in_ack    <= 1'b0;
      add_a     <= '0;
      add_a_stb <= 1'b0;
      add_b     <= '0;
      add_b_stb <= 1'b0;
      add_z_ack <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_stb   <= 1'b0;
    end else begin
      case (state)
        GET_FIRST: begin
          in_ack <= 1'b1;
          if (in_xfer) begin
            // first element is taken verbatim, so its exact bits (-0.0, NaN) survive
            acc    <= in_data;
            count  <= COUNT_W'(1);
            last_q <= in_last;
            if (in_last) begin
              in_ack    <= 1'b0;
              out_sum   <= in_data;
              out_count <= COUNT_W'(1);
              out_stb   <= 1'b1;
              state     <= PUT_SUM;
            end else
              state <= GET_NEXT;
          end
        end
        GET_NEXT: begin
          in_ack <= 1'b1;
          if (in_xfer) begin
            in_ack    <= 1'b0;
            add_a     <= acc;
            add_b     <= in_data;
            add_a_stb <= 1'b1;
            add_b_stb <= 1'b1;
            last_q    <= in_last;
            count     <= (count == COUNT_MAX) ? count : count + COUNT_W'(1);
            state     <= SEND_AB;
          end
        end
        SEND_AB: begin
          if (add_a_ack) add_a_stb <= 1'b0;
          if (add_b_ack) add_b_stb <= 1'b0;
          if (a_done && b_done) begin
            add_z_ack <= 1'b1;
            state     <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (z_xfer) begin
            acc       <= add_z;
            add_z_ack <= 1'b0;
            if (last_q) begin
              out_sum   <= add_z;
              out_count <= count;
              out_stb   <= 1'b1;
              state     <= PUT_SUM;
            end else begin
              in_ack <= 1'b1;
              state  <= GET_NEXT;
            end
          end
        end
        PUT_SUM: begin
          if (out_ack) begin
            out_stb <= 1'b0;
            in_ack  <= 1'b1;
            state   <= GET_FIRST;
          end
        end
        default: state <= GET_FIRST;
      endcase
    end
endmodule

// File: tb/tb_double_sum_reducer.sv
// tb_double_sum_reducer: randomized scoreboard bench with a behavioural adder and group-sum model
module tb_double_sum_reducer;
  import double_sum_pkg::*;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic [63:0] in_data = '0, add_a, add_b, add_z = '0, out_sum;
  logic in_last = 0, in_stb = 0, in_ack;
  logic add_a_stb, add_a_ack = 0, add_b_stb, add_b_ack = 0, add_z_stb = 0, add_z_ack;
  logic [CW-1:0] out_count;
  logic out_stb, out_ack = 0;
  always #5 clk = ~clk;
  double_sum_reducer #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_stb(in_stb), .in_ack(in_ack),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .out_sum(out_sum), .out_count(out_count), .out_stb(out_stb), .out_ack(out_ack));
  typedef struct { logic [63:0] sum; int cnt; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, nout = 0, n_astb = 0;
  int a_dly = 0, b_dly = 0, z_dly = 0;
  bit hold = 0, ack_rand = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction
  function automatic exp_t model(input logic [63:0] el[$]);
    exp_t e;
    e.sum = el[0];
    for (int i = 1; i < el.size(); i++) e.sum = fadd(e.sum, el[i]);
    e.cnt = (el.size() > MAXC) ? MAXC : el.size();
    return e;
  endfunction
  function automatic logic [63:0] rnd_dbl();
    return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 16.0);
  endfunction
  // behavioural double_adder: takes each operand once, answers with a+b after z_dly cycles
  initial begin : adder
    logic [63:0] cap_a, cap_b;
    bit ha = 0, hb = 0, xa, xb, xz;
    int ca = 0, cb = 0, cz = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ha = 0; hb = 0;
      end else begin
        if (add_a_stb) n_astb++;
        if (ha && !hb) begin
          chk("a_stb_dropped", add_a_stb, 0);
          chk("b_stb_held", add_b_stb, 1);
        end
        xa = add_a_stb && add_a_ack;
        xb = add_b_stb && add_b_ack;
        xz = add_z_stb && add_z_ack;
        if (xa) begin chk("dup_a", ha, 0); ha = 1; cap_a = add_a; end
        if (xb) begin chk("dup_b", hb, 0); hb = 1; cap_b = add_b; end
        if (xz) begin ha = 0; hb = 0; end
      end
      @(posedge clk); #1;
      if (!rst) begin
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; ca = 0; cb = 0; cz = 0; ha = 0; hb = 0;
        continue;
      end
      if (xa) begin add_a_ack = 0; ca = 0; end
      else if (add_a_stb) begin add_a_ack = (ca >= a_dly); ca++; end
      if (xb) begin add_b_ack = 0; cb = 0; end
      else if (add_b_stb) begin add_b_ack = (cb >= b_dly); cb++; end
      if (xz) add_z_stb = 0;
      if (ha && hb && !add_z_stb) begin
        if (cz >= z_dly) begin add_z = fadd(cap_a, cap_b); add_z_stb = 1; cz = 0; end
        else cz++;
      end
    end
  end
  initial forever begin
    @(posedge clk); #1;
    out_ack = hold ? 1'b0 : (ack_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end
  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (rst && out_stb && out_ack) begin
      nout++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out actual=%h expected=none", out_sum);
      end else begin
        e = exp_q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_count", 64'(out_count), 64'(e.cnt));
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end
  task automatic push(input logic [63:0] d, input logic l);
    bit t = 0;
    in_data = d; in_last = l; in_stb = 1;
    for (int n = 0; n < 1000 && !t; n++) begin @(negedge clk); t = in_ack; end
    if (!t) begin checks++; failures++; $display("FAIL in_timeout actual=0 expected=1"); end
    @(posedge clk); #1;
    in_stb = 0;
  endtask
  task automatic send_group(input logic [63:0] el[$]);
    exp_q.push_back(model(el));
    foreach (el[i]) push(el[i], i == el.size() - 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask
  initial begin : main
    logic [63:0] g[$], hs;
    logic [CW-1:0] hc;
    int n0;
    bit seen;
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ack", in_ack, 0); chk("rst_a_stb", add_a_stb, 0); chk("rst_b_stb", add_b_stb, 0);
    chk("rst_z_ack", add_z_ack, 0); chk("rst_out_stb", out_stb, 0); chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", 64'(out_count), 0); chk("rst_add_a", add_a, 0); chk("rst_add_b", add_b, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(negedge clk);
    chk("in_ack_after_rst", in_ack, 1);
    @(posedge clk); #1;
    n0 = nout;
    g = {DBL_ONE, 64'h4000000000000000, 64'h4008000000000000};
    send_group(g);
    drain();
    repeat (5) @(negedge clk);
    chk("sum6_pulses", 64'(nout - n0), 1);
    chk("sum6_bits", out_sum, 64'h4018000000000000);
    @(posedge clk); #1;
    n0 = n_astb;
    g = {64'hBFF8000000000000};
    send_group(g);
    @(negedge clk);
    chk("single_latency", out_stb, 1);
    chk("single_bits", out_sum, 64'hBFF8000000000000);
    drain();
    chk("single_no_add", 64'(n_astb - n0), 0);
    hold = 1;
    g = {DBL_ONE, rnd_dbl()};
    send_group(g);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin @(negedge clk); seen = out_stb; end
    chk("hold_out_stb", seen, 1);
    hs = out_sum; hc = out_count;
    for (int i = 0; i < 20; i++) begin
      chk("hold_sum", out_sum, hs); chk("hold_count", 64'(out_count), 64'(hc));
      chk("hold_in_ack", in_ack, 0);
      if (i < 19) @(negedge clk);
    end
    hold = 0;
    @(negedge clk); @(negedge clk);
    chk("release_in_ack", in_ack, 1);
    chk("release_out_stb", out_stb, 0);
    drain();
    a_dly = 0; b_dly = 3;
    g = {rnd_dbl(), rnd_dbl(), rnd_dbl()};
    send_group(g);
    drain();
    b_dly = 0; z_dly = 10;
    push(DBL_ONE, 0);
    push(64'h4000000000000000, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = add_z_ack; end
    chk("reach_wait_z", seen, 1);
    @(posedge clk); #1 rst = 0; #1;
    chk("mid_in_ack", in_ack, 0); chk("mid_a_stb", add_a_stb, 0); chk("mid_b_stb", add_b_stb, 0);
    chk("mid_z_ack", add_z_ack, 0); chk("mid_out_stb", out_stb, 0); chk("mid_add_a", add_a, 0);
    chk("mid_add_b", add_b, 0); chk("mid_out_sum", out_sum, 0); chk("mid_out_count", 64'(out_count), 0);
    @(posedge clk); #1 rst = 1;
    z_dly = 0;
    g = {64'h3FE0000000000000, 64'h3FD0000000000000};
    send_group(g);
    drain();
    chk("after_rst_sum", out_sum, 64'h3FE8000000000000);
    chk("after_rst_count", 64'(out_count), 2);
    g = {$realtobits(3.14), $realtobits(-3.14)};
    send_group(g);
    drain();
    chk("cancel_zero", out_sum, DBL_POS_ZERO);
    g.delete();
    repeat ((1 << CW) + 5) g.push_back(DBL_POS_ZERO);
    send_group(g);
    drain();
    chk("sat_count", 64'(out_count), 64'(MAXC));
    ack_rand = 1;
    for (int k = 0; k < 30; k++) begin
      a_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3); z_dly = $urandom_range(0, 3);
      g.delete();
      repeat ($urandom_range(1, 6)) g.push_back(rnd_dbl());
      send_group(g);
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
